aes_req_arbiter: RTL and testbench

Shares one fully pipelined AES-128 encryption core between two requesters. The core takes a plaintext and key every cycle and returns ciphertext a fixed CORE_LAT cycles later with `valid`. The block arbitrates requests round-robin and drives the core's P/K inputs. A tag pipeline tracks every in-flight block and routes each ciphertext back to its issuer. A flush FSM drains the core on command.

---
 rtl/aes_arb_pkg.sv | 19 +
 rtl/aes_tag_pipe.sv | 49 ++++
 rtl/aes_req_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_aes_req_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the two-requester AES core arbiter.
package aes_arb_pkg;

  localparam int unsigned BlockW = 128;
  localparam int unsigned NumReq = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } arb_state_e;

  // One tag per core pipeline slot: v marks a live block, id names its issuer.
  typedef struct packed {
    logic v;
    logic id;
  } tag_t;

endpackage

// File: rtl/aes_tag_pipe.sv
// Tag shift register that tracks blocks in flight through the AES core.
// A tag enters at stage 0 every cycle (v=0 when nothing was issued) and
// leaves from the last stage; inflight counts the live tags held.
module aes_tag_pipe
  import aes_arb_pkg::*;
#(
  parameter int unsigned Depth = 12,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  tag_t            tag_new,
  output tag_t            tag_last,
  output logic [CntW-1:0] inflight
);

  tag_t            pipe_q [Depth];
  logic [CntW-1:0] cnt_q, cnt_d;

  assign tag_last = pipe_q[Depth-1];
  assign inflight = cnt_q;

  // Live-tag count: +1 on a live push, -1 on a live pop, unchanged when both.
  always_comb begin
    cnt_d = cnt_q;
    if (tag_new.v && !tag_last.v) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!tag_new.v && tag_last.v) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Shift register and count; reset drops every tag in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        pipe_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      pipe_q[0] <= tag_new;
      for (int i = 1; i < Depth; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one pipelined AES-128 core between two requesters.
// Ciphertexts are routed back to their issuer via a tag pipeline; flush drains
// the core. Optional macro AES_ARB_STATS_EN adds grant/stall counters.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned CORE_LAT  = 11,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NumReq-1:0] req_valid,
  output logic [NumReq-1:0] req_ready,
  input  logic [BlockW-1:0] req_p0,
  input  logic [BlockW-1:0] req_k0,
  input  logic [BlockW-1:0] req_p1,
  input  logic [BlockW-1:0] req_k1,
  output logic [NumReq-1:0] rsp_valid,
  output logic [BlockW-1:0] rsp_c,
  output logic [BlockW-1:0] core_p,
  output logic [BlockW-1:0] core_k,
  input  logic [BlockW-1:0] core_c,
  input  logic              core_valid,
  input  logic              flush,
  output logic              flush_done,
  output logic              err
`ifdef AES_ARB_STATS_EN
  ,
  output logic [31:0]       grant_cnt0,
  output logic [31:0]       grant_cnt1,
  output logic [31:0]       stall_cnt
`endif
);

  // The extra stage accounts for the core_p/core_k register ahead of the core,
  // so a tag reaches the last stage exactly when its ciphertext is on core_c.
  localparam int unsigned PipeDepth = CORE_LAT + 1;
  localparam int unsigned InflW     = $clog2(PipeDepth + 1);
  localparam int unsigned OutW      = $clog2(MAX_OUTST + 1);

  tag_t              tag_new, tag_last;
  logic [InflW-1:0]  inflight;
  logic [OutW-1:0]   outst_q [NumReq];
  logic              rr_q;
  arb_state_e        state_q;
  logic              done_sent_q;
  logic [NumReq-1:0] elig, grant, ret;
  logic              pipe_empty, done_fire;

  aes_tag_pipe #(
    .Depth (PipeDepth),
    .CntW  (InflW)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .tag_new  (tag_new),
    .tag_last (tag_last),
    .inflight (inflight)
  );

  assign pipe_empty = (inflight == '0);
  assign done_fire  = (state_q == StDrain) && pipe_empty && !done_sent_q;

  // Decode the returning tag into a one-hot per-requester return.
  always_comb begin
    ret = '0;
    if (tag_last.v) begin
      ret[tag_last.id] = 1'b1;
    end
  end

  // Eligibility; a return this cycle frees a slot for a same-cycle grant.
  // flush gates issue immediately, before the FSM has reached DRAIN.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NumReq; i++) begin
      elig[i] = req_valid[i] && !flush && (state_q != StDrain) &&
                ((outst_q[i] < OutW'(MAX_OUTST)) || ret[i]);
    end
  end

  // Single grant per cycle, round-robin only on contention.
  always_comb begin
    grant = '0;
    unique case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  assign req_ready  = grant;
  assign tag_new.v  = |grant;
  assign tag_new.id = grant[1];

  // Issue registers toward the core and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_p <= '0;
      core_k <= '0;
      rr_q   <= 1'b0;
    end else begin
      if (grant[0]) begin
        core_p <= req_p0;
        core_k <= req_k0;
      end else if (grant[1]) begin
        core_p <= req_p1;
        core_k <= req_k1;
      end
      if (elig == 2'b11) begin
        rr_q <= ~rr_q;
      end
    end
  end

  // Per-requester outstanding counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumReq; i++) begin
        outst_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (grant[i] && !ret[i]) begin
          outst_q[i] <= outst_q[i] + 1'b1;
        end else if (!grant[i] && ret[i]) begin
          outst_q[i] <= outst_q[i] - 1'b1;
        end
      end
    end
  end

  // Response capture; a missing core_valid on a live return is flagged, not dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_c     <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= ret;
      if (tag_last.v) begin
        rsp_c <= core_c;
        if (!core_valid) begin
          err <= 1'b1;
        end
      end
    end
  end

  // Control FSM with registered flush_done; one pulse per flush assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      done_sent_q <= 1'b0;
      flush_done  <= 1'b0;
    end else begin
      flush_done <= done_fire;
      unique case (state_q)
        StIdle: begin
          if (flush) begin
            state_q     <= StDrain;
            done_sent_q <= 1'b0;
          end else if (|grant) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (flush) begin
            state_q     <= StDrain;
            done_sent_q <= 1'b0;
          end else if (pipe_empty && !(|grant)) begin
            state_q <= StIdle;
          end
        end
        StDrain: begin
          if (pipe_empty && !flush) begin
            state_q     <= StIdle;
            done_sent_q <= 1'b0;
          end else if (done_fire) begin
            done_sent_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef AES_ARB_STATS_EN
  // Grant and stall statistics, cleared whenever a drain completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      stall_cnt  <= '0;
    end else if (done_fire) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      stall_cnt  <= '0;
    end else begin
      if (grant[0]) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (grant[1]) grant_cnt1 <= grant_cnt1 + 32'd1;
      if ((|req_valid) && !(|grant)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Scoreboard bench for aes_req_arbiter with a behavioural stand-in AES core.
module tb_aes_req_arbiter;
  import aes_arb_pkg::*;

  localparam int unsigned L      = 11;
  localparam int unsigned MaxOut = 8;
  localparam logic [127:0] FipsP = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FipsK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsC = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [127:0] req_p0 = '0, req_k0 = '0, req_p1 = '0, req_k1 = '0;
  logic [1:0]   rsp_valid;
  logic [127:0] rsp_c, core_p, core_k, core_c;
  logic         core_valid;
  logic         flush = 1'b0;
  logic         flush_done, err;
  logic         kill_valid = 1'b0;

  always #5 clk = ~clk;

  aes_req_arbiter #(
    .CORE_LAT  (L),
    .MAX_OUTST (MaxOut)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_p0     (req_p0),
    .req_k0     (req_k0),
    .req_p1     (req_p1),
    .req_k1     (req_k1),
    .rsp_valid  (rsp_valid),
    .rsp_c      (rsp_c),
    .core_p     (core_p),
    .core_k     (core_k),
    .core_c     (core_c),
    .core_valid (core_valid),
    .flush      (flush),
    .flush_done (flush_done),
    .err        (err)
  );

  // Stand-in core: real ciphertext for the FIPS-197 vector, a keyed mix otherwise.
  function automatic logic [127:0] fake_aes(input logic [127:0] p, input logic [127:0] k);
    if (p == FipsP && k == FipsK) return FipsC;
    return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0000_a5a5_ffff_1234_5678_9abc_def0;
  endfunction

  // Core pipeline: samples core_p/core_k every edge, output L edges later.
  logic [127:0] core_c_pipe [L];
  logic         core_v_pipe [L];
  always @(posedge clk) begin
    core_c_pipe[0] <= fake_aes(core_p, core_k);
    core_v_pipe[0] <= 1'b1;
    for (int i = 1; i < L; i++) begin
      core_c_pipe[i] <= core_c_pipe[i-1];
      core_v_pipe[i] <= core_v_pipe[i-1];
    end
  end
  assign core_c     = core_c_pipe[L-1];
  assign core_valid = core_v_pipe[L-1] & ~kill_valid;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic         id;
    logic [127:0] c;
    int           at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid != 2'b00) begin
      check("rsp_onehot", 128'($countones(rsp_valid)), 128'd1);
      if (sb.size() == 0) begin
        check("unexpected_rsp", 128'(rsp_valid), 128'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_owner", 128'(rsp_valid), mon_e.id ? 128'd2 : 128'd1);
        check("rsp_c", rsp_c, mon_e.c);
        check("rsp_cycle", 128'(cyc), 128'(mon_e.at));
      end
    end
  end

  // One stimulus cycle: drive at negedge, then record any accepted block.
  task automatic step(input logic [1:0] v, input logic [127:0] p0, input logic [127:0] k0,
                      input logic [127:0] p1, input logic [127:0] k1, input logic f);
    exp_t e;
    @(negedge clk);
    req_valid = v;
    req_p0 = p0; req_k0 = k0; req_p1 = p1; req_k1 = k1;
    flush = f;
    #1;
    if (v[0] && req_ready[0]) begin
      e.id = 1'b0; e.c = fake_aes(p0, k0); e.at = cyc + L + 2;
      sb.push_back(e);
    end
    if (v[1] && req_ready[1]) begin
      e.id = 1'b1; e.c = fake_aes(p1, k1); e.at = cyc + L + 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      idle(1);
      guard++;
    end
    check("drain_empty", 128'(sb.size()), 128'd0);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int last_acc;
    int exp_done;
    logic got;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 128'(req_ready), 128'd0);
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_rsp_c", rsp_c, 128'd0);
    check("rst_core_p", core_p, 128'd0);
    check("rst_core_k", core_k, 128'd0);
    check("rst_flush_done", 128'(flush_done), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_state", 128'(dut.state_q), 128'(StIdle));
    check("rst_outst0", 128'(dut.outst_q[0]), 128'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: requester 0 streams the FIPS-197 vector
    for (int k = 0; k < 6; k++) begin
      step(2'b01, FipsP, FipsK, '0, '0, 1'b0);
      check("t1_ready", 128'(req_ready), 128'd1);
    end
    drain();

    // 2: both requesters contend; grants alternate starting with requester 0
    for (int k = 0; k < 10; k++) begin
      step(2'b11, 128'h1000 + 128'(k), 128'hbeef, 128'h2000 + 128'(k), 128'hcafe, 1'b0);
      check("t2_ready", 128'(req_ready), (k % 2 == 0) ? 128'd1 : 128'd2);
    end
    drain();

    // 3: requester 1 saturates its outstanding limit
    for (int k = 0; k < L + 4; k++) begin
      step(2'b10, '0, '0, 128'h3000 + 128'(k), 128'h77, 1'b0);
      check("t3_ready", 128'(req_ready), (k < MaxOut || k >= L + 1) ? 128'd2 : 128'd0);
      if (k == MaxOut || k == L + 2) begin
        check("t3_outst_full", 128'(dut.outst_q[1]), 128'(MaxOut));
      end
    end
    drain();

    // 4: flush with five blocks in flight
    last_acc = 0;
    for (int k = 0; k < 5; k++) begin
      step(2'b01, 128'h4000 + 128'(k), 128'h99, '0, '0, 1'b0);
      check("t4_ready", 128'(req_ready), 128'd1);
      last_acc = cyc;
    end
    exp_done = last_acc + L + 3;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      step(2'b01, 128'h4100, 128'h99, '0, '0, 1'b1);
      check("t4_ready_flush", 128'(req_ready), 128'd0);
      if (flush_done) begin
        got = 1'b1;
        check("t4_done_cycle", 128'(cyc), 128'(exp_done));
      end
    end
    check("t4_done_seen", 128'(got), 128'd1);
    check("t4_all_rsp", 128'(sb.size()), 128'd0);
    for (int k = 0; k < 3; k++) begin
      step(2'b00, '0, '0, '0, '0, 1'b1);
      check("t4_single_pulse", 128'(flush_done), 128'd0);
    end
    idle(2);
    check("t4_state_idle", 128'(dut.state_q), 128'(StIdle));
    check("t4_err_clear", 128'(err), 128'd0);

    // 6: core_valid withheld on the return cycle
    step(2'b10, '0, '0, 128'h6000, 128'h66, 1'b0);
    check("t6_ready", 128'(req_ready), 128'd2);
    kill_valid = 1'b1;
    drain();
    kill_valid = 1'b0;
    check("t6_err_set", 128'(err), 128'd1);
    idle(5);
    check("t6_err_sticky", 128'(err), 128'd1);

    // 5: reset with three blocks in flight
    for (int k = 0; k < 3; k++) begin
      step(2'b01, 128'h5000 + 128'(k), 128'h55, '0, '0, 1'b0);
      check("t5_ready", 128'(req_ready), 128'd1);
    end
    idle(2);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(L + 6);
    check("t5_outst0", 128'(dut.outst_q[0]), 128'd0);
    check("t5_outst1", 128'(dut.outst_q[1]), 128'd0);
    check("t5_err", 128'(err), 128'd0);
    check("t5_state", 128'(dut.state_q), 128'(StIdle));

    // Recovery after reset
    step(2'b01, FipsP, FipsK, '0, '0, 1'b0);
    check("post_rst_ready", 128'(req_ready), 128'd1);
    drain();
    check("final_sb_empty", 128'(sb.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
